data_stream_rx: RTL and testbench
=================================

// Module: data_stream_rx
// PURPOSE
// - Receive-side counterpart of the byte-stream source: consumes AXI-Stream-style 8-bit frames of
//   the form [LEN_HI][LEN_LO][payload x LEN], with tlast on the final byte.
// - Validates the header against the actual frame length, stores the payload in a local buffer
//   and presents the completed frame to downstream logic via a random-access read port.
// - Sits at the MAC-side ingress, directly downstream of any frame source on the byte bus.
// PARAMETERS
// - MAX_LEN  default 64   payload buffer depth in bytes; longer declared lengths are errors
// - ADDR_W   default 6    read-address width; must satisfy 2**ADDR_W >= MAX_LEN
// PORTS
// - clk          in   1       single clock domain
// - reset_n      in   1       asynchronous assert, active-low reset
// - tvalid       in   1       upstream byte valid
// - tready       out  1       byte accepted when tvalid && tready
// - tlast        in   1       final byte of frame
// - char         in   8       byte data
// - frame_valid  out  1       completed good frame held in buffer
// - frame_len    out  16      payload length of held frame
// - frame_ack    in   1       consumer releases buffer; sampled only while frame_valid
// - rd_addr      in   ADDR_W  payload byte index (0 = first payload byte)
// - rd_data      out  8       combinational buffer read; 0 when rd_addr >= frame_len
// - err_pulse    out  1       one-cycle pulse per malformed frame
// - frame_cnt    out  16      good frames received, wraps
// - err_cnt      out  16      malformed frames, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset: state LEN_HI; tready=0 for exactly the reset cycle, then 1; frame_valid=0,
//   frame_len=0, err_pulse=0, frame_cnt=0, err_cnt=0. Buffer contents are not reset.
// - FSM, one beat per accepted byte:
//   LEN_HI : store len[15:8]; tlast -> error, stay LEN_HI; else -> LEN_LO
//   LEN_LO : store len[7:0]; len>MAX_LEN -> error (DRAIN, or LEN_HI if tlast);
//            tlast && len==0 -> DONE; tlast && len!=0 -> error short, LEN_HI;
//            !tlast && len==0 -> error long, DRAIN; else -> PAYLOAD, idx=0
//   PAYLOAD: write buf[idx]; idx==len-1: tlast -> DONE, else error long -> DRAIN;
//            idx<len-1 && tlast -> error short, LEN_HI; else idx++
//   DRAIN  : accept and discard; tlast -> LEN_HI
//   DONE   : tready=0, frame_valid=1, frame_len=len; frame_ack -> LEN_HI next cycle
// - tready=1 in LEN_HI, LEN_LO, PAYLOAD, DRAIN; 0 in DONE. Gaps in tvalid stall the FSM.
// - Latency: frame_valid rises the cycle after the tlast beat is accepted; frame_cnt
//   increments in that same cycle. err_pulse and err_cnt update the cycle after the bad beat.
// - frame_ack with frame_valid=0 is ignored; no new byte accepted before DONE exits.
// - Async reset mid-frame discards the partial frame without counting an error.
// CONFIGURATION
// - DATA_STREAM_RX_CHECK_EN defined: adds param EXP_LEN (default 11) and
//   EXP_MSG (default "HELLO WORLD"), output match (1 bit, reset 0); at DONE entry
//   match=1 iff len==EXP_LEN and every payload byte equals EXP_MSG, MSB-first; cleared on ack.
// - Undefined: no match port, no comparison logic, no EXP_* parameters.
// STRUCTURE
// - data_stream_pkg: state enum rx_state_t {LEN_HI, LEN_LO, PAYLOAD, DRAIN, DONE}, HDR_BYTES=2,
//   CNT_W=16. Shared with the source side.
// - One sub-module: data_stream_rx_buf (MAX_LEN x 8, 1 sync write, 1 async read).
// - Top holds FSM, length/index registers, counters, optional checker.
// TESTING
// - 00 0B "HELLO WORLD", tlast on byte 13 -> frame_valid=1, frame_len=11, rd_data@0=8'h48,
//   @10=8'h44, tready=0 until frame_ack; frame_cnt=1; match=1 with CHECK_EN.
// - 00 05 + 3 bytes, tlast on byte 5 -> err_pulse once, err_cnt=1, FSM LEN_HI, frame_valid=0.
// - 00 02 + 4 bytes, tlast on byte 6 -> error at byte 4, remaining bytes drained, err_cnt=1.
// - 00 41 (65 > MAX_LEN) + 65 bytes -> error, all drained; following 00 00 with tlast -> frame_len=0.
// - Valid frame with random tvalid gaps -> identical result; hold DONE 10 cycles, tready stays 0.
// - Assert reset_n low mid-payload -> outputs at reset values, err_cnt unchanged; next frame good.

Source files
------------

// File: rtl/data_stream_pkg.sv
// Types and constants shared by the data_stream byte-bus source and receiver.
// Frame on the wire: [LEN_HI][LEN_LO][payload x LEN], tlast on the final byte.
package data_stream_pkg;
  localparam int HDR_BYTES = 2;
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {LEN_HI, LEN_LO, PAYLOAD, DRAIN, DONE} rx_state_t;
endpackage

// File: rtl/data_stream_rx_buf.sv
// Payload buffer: DEPTH x 8, one synchronous write port, one combinational read port.
// Contents are intentionally not reset; out-of-range reads return 0.
module data_stream_rx_buf #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : 8'h00;
endmodule

// File: rtl/data_stream_rx.sv
// Frame receiver: checks [LEN_HI][LEN_LO][payload] against tlast, buffers good payloads.
// frame_valid/frame_cnt rise one cycle after the tlast beat; err_pulse/err_cnt one cycle after a bad beat.
// tready drops while a good frame is held until frame_ack. DATA_STREAM_RX_CHECK_EN adds the EXP_MSG match output.
module data_stream_rx
  import data_stream_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int ADDR_W  = 6
`ifdef DATA_STREAM_RX_CHECK_EN
  ,
  parameter int EXP_LEN = 11,
  parameter logic [8*EXP_LEN-1:0] EXP_MSG = "HELLO WORLD"
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tvalid,
  output logic              tready,
  input  logic              tlast,
  input  logic [7:0]        char,
  output logic              frame_valid,
  output logic [CNT_W-1:0]  frame_len,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
`ifdef DATA_STREAM_RX_CHECK_EN
  ,
  output logic              match
`endif
);
  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  len_q, hdr_len;
  logic [ADDR_W-1:0] idx_q;
  logic              rdy_q, beat, at_last, err_now, wr_en, done_entry;
  logic [7:0]        buf_rd;

  assign beat       = tvalid && tready;
  assign hdr_len    = {len_q[CNT_W-1:8], char};
  assign at_last    = (CNT_W'(idx_q) == len_q - CNT_W'(1));
  assign done_entry = (state_d == DONE) && (state_q != DONE);

  always_comb begin
    state_d = state_q;
    err_now = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      LEN_HI: if (beat) begin
        if (tlast) err_now = 1'b1;
        else       state_d = LEN_LO;
      end
      LEN_LO: if (beat) begin
        if (hdr_len > CNT_W'(MAX_LEN)) begin
          err_now = 1'b1;
          state_d = tlast ? LEN_HI : DRAIN;
        end else if (hdr_len == '0) begin
          err_now = !tlast;
          state_d = tlast ? DONE : DRAIN;
        end else if (tlast) begin
          err_now = 1'b1;
          state_d = LEN_HI;
        end else begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (beat) begin
        wr_en = 1'b1;
        if (at_last) begin
          err_now = !tlast;
          state_d = tlast ? DONE : DRAIN;
        end else if (tlast) begin
          err_now = 1'b1;
          state_d = LEN_HI;
        end
      end
      DRAIN: if (beat && tlast) state_d = LEN_HI;
      DONE:  if (frame_ack) state_d = LEN_HI;
      default: state_d = LEN_HI;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= LEN_HI;
      rdy_q     <= 1'b0;
      len_q     <= '0;
      idx_q     <= '0;
      err_pulse <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      err_pulse <= err_now;
      if (beat && state_q == LEN_HI) len_q[CNT_W-1:8] <= char;
      if (beat && state_q == LEN_LO) len_q[7:0] <= char;
      if (beat && state_q == LEN_LO) idx_q <= '0;
      else if (wr_en)                idx_q <= idx_q + ADDR_W'(1);
      if (done_entry) frame_cnt <= frame_cnt + CNT_W'(1);
      if (err_now && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  // rdy_q keeps tready low through the reset cycle even though the state is LEN_HI.
  assign tready      = rdy_q && (state_q != DONE);
  assign frame_valid = (state_q == DONE);
  assign frame_len   = frame_valid ? len_q : '0;
  assign rd_data     = (CNT_W'(rd_addr) < frame_len) ? buf_rd : 8'h00;

  data_stream_rx_buf #(.DEPTH(MAX_LEN), .ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (idx_q),
    .wr_data (char),
    .rd_addr (rd_addr),
    .rd_data (buf_rd)
  );

`ifdef DATA_STREAM_RX_CHECK_EN
  logic [CNT_W-1:0] len_cur;
  logic [7:0]       exp_byte;
  logic             exp_hit, byte_ok, chk_ok_q;

  assign len_cur = (state_q == LEN_LO) ? hdr_len : len_q;

  always_comb begin
    exp_byte = 8'h00;
    exp_hit  = 1'b0;
    for (int i = 0; i < EXP_LEN; i++) begin
      if (int'(idx_q) == i) begin
        exp_byte = EXP_MSG[8*(EXP_LEN-1-i) +: 8];
        exp_hit  = 1'b1;
      end
    end
  end

  assign byte_ok = exp_hit && (char == exp_byte);

  // chk_ok_q covers bytes already written; the tlast byte is folded in at DONE entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_ok_q <= 1'b1;
      match    <= 1'b0;
    end else begin
      if (beat && state_q == LEN_LO) chk_ok_q <= 1'b1;
      else if (wr_en && !byte_ok)    chk_ok_q <= 1'b0;
      if (done_entry)
        match <= (len_cur == CNT_W'(EXP_LEN)) && ((state_q == LEN_LO) || (chk_ok_q && byte_ok));
      else if (frame_valid && frame_ack)
        match <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_data_stream_rx.sv
// Randomised self-checking bench for data_stream_rx against a per-frame outcome model.
module tb_data_stream_rx;
  localparam int MAX_LEN = 64;
  localparam int ADDR_W  = 6;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0, reset_n = 1'b0;
  logic              tvalid = 1'b0, tlast = 1'b0, frame_ack = 1'b0;
  logic [7:0]        char = 8'h00;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              tready, frame_valid, err_pulse;
  logic [15:0]       frame_len, frame_cnt, err_cnt;
  logic [7:0]        rd_data;
`ifdef DATA_STREAM_RX_CHECK_EN
  logic              match;
`endif

  int          n_checks = 0, n_fail = 0;
  logic [15:0] exp_frames = 16'd0, exp_errs = 16'd0;

  always #5 clk = ~clk;

  data_stream_rx #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .char(char), .frame_valid(frame_valid), .frame_len(frame_len), .frame_ack(frame_ack),
    .rd_addr(rd_addr), .rd_data(rd_data), .err_pulse(err_pulse), .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
`ifdef DATA_STREAM_RX_CHECK_EN
    , .match(match)
`endif
  );

  // Outcome of one tlast-terminated frame: beat index where the error is detected, -1 if good.
  function automatic int model_err_beat(input bq_t f);
    int n, len;
    n = f.size();
    if (n < 2) return 0;
    len = int'({f[0], f[1]});
    if (len > MAX_LEN) return 1;
    if (n - 2 == len) return -1;
    if (n - 2 < len) return n - 1;
    return len + 1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic bit model_match(input bq_t f);
    string s;
    s = "HELLO WORLD";
    if (f.size() != 13 || f[0] != 8'h00 || f[1] != 8'd11) return 1'b0;
    for (int i = 0; i < 11; i++) if (f[2+i] != s[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Each call starts and ends on a falling edge; returns just after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps);
    int n;
    n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    tvalid = 1'b1; char = b; tlast = last;
    frame_ack = last ? 1'b0 : 1'($urandom_range(0, 1));
    while (tready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (tready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout tready=%b required=1", tready);
    end
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; frame_ack = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input bit gaps, output int first_err, output int n_err);
    first_err = -1; n_err = 0;
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], (i == f.size() - 1), gaps);
      if (err_pulse === 1'b1) begin
        if (first_err < 0) first_err = i;
        n_err++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got=%b req=0", tready); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid got=%b req=0", frame_valid); end
    n_checks++; if (frame_len !== 16'd0) begin n_fail++; $display("FAIL reset_frame_len got=%0d req=0", frame_len); end
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse got=%b req=0", err_pulse); end
    n_checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters got=%0d/%0d req=0/0", frame_cnt, err_cnt);
    end
`ifdef DATA_STREAM_RX_CHECK_EN
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match got=%b req=0", match); end
`endif
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (tready !== 1'b1) begin n_fail++; $display("FAIL post_reset_tready got=%b req=1", tready); end
  endtask

  task automatic test_hello();
    bq_t f;
    string s;
    int fe, ne;
    s = "HELLO WORLD";
    f = {8'h00, 8'h0B};
    for (int i = 0; i < s.len(); i++) f.push_back(s[i]);
    send_frame(f, 1'b0, fe, ne);
    exp_frames++;
    n_checks++; if (ne !== 0) begin n_fail++; $display("FAIL hello_err_pulses got=%0d req=0", ne); end
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL hello_frame_valid got=%b req=1", frame_valid); end
    n_checks++; if (frame_len !== 16'd11) begin n_fail++; $display("FAIL hello_frame_len got=%0d req=11", frame_len); end
    n_checks++; if (frame_cnt !== exp_frames) begin n_fail++; $display("FAIL hello_frame_cnt got=%0d req=%0d", frame_cnt, exp_frames); end
`ifdef DATA_STREAM_RX_CHECK_EN
    n_checks++; if (match !== 1'b1) begin n_fail++; $display("FAIL hello_match got=%b req=1", match); end
`endif
    rd_addr = 6'd0; #1;
    n_checks++; if (rd_data !== 8'h48) begin n_fail++; $display("FAIL hello_rd0 got=%h req=48", rd_data); end
    rd_addr = 6'd10; #1;
    n_checks++; if (rd_data !== 8'h44) begin n_fail++; $display("FAIL hello_rd10 got=%h req=44", rd_data); end
    rd_addr = 6'd11; #1;
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL hello_rd11 got=%h req=00", rd_data); end
    // Offer a byte throughout the hold: it must not be taken while the frame is held.
    tvalid = 1'b1; char = 8'hAA; tlast = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++; if (tready !== 1'b0 || frame_valid !== 1'b1) begin
        n_fail++; $display("FAIL hello_hold cycle=%0d tready=%b frame_valid=%b req=0/1", c, tready, frame_valid);
      end
    end
    tvalid = 1'b0; tlast = 1'b0;
    frame_ack = 1'b1; @(negedge clk); frame_ack = 1'b0;
    n_checks++; if (frame_valid !== 1'b0 || tready !== 1'b1) begin
      n_fail++; $display("FAIL hello_ack frame_valid=%b tready=%b req=0/1", frame_valid, tready);
    end
`ifdef DATA_STREAM_RX_CHECK_EN
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL hello_match_clear got=%b req=0", match); end
`endif
  endtask

  task automatic test_errors();
    bq_t f;
    int fe, ne, eb;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: f = {8'h00, 8'h05, 8'h01, 8'h02, 8'h03};
        1: f = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        2: f = {8'h7E};
        3: f = {8'h00, 8'h00, 8'h55, 8'h66};
        4: f = {8'h00, 8'h03};
        default: begin
          f = {8'h00, 8'h41};
          repeat (65) f.push_back(8'($urandom));
        end
      endcase
      eb = model_err_beat(f);
      send_frame(f, 1'b0, fe, ne);
      exp_errs = sat_inc(exp_errs);
      n_checks++; if (fe !== eb || ne !== 1) begin
        n_fail++; $display("FAIL err_case%0d_pulse first=%0d count=%0d req=%0d/1", k, fe, ne, eb);
      end
      n_checks++; if (err_cnt !== exp_errs) begin n_fail++; $display("FAIL err_case%0d_cnt got=%0d req=%0d", k, err_cnt, exp_errs); end
      n_checks++; if (frame_valid !== 1'b0 || tready !== 1'b1) begin
        n_fail++; $display("FAIL err_case%0d_state frame_valid=%b tready=%b req=0/1", k, frame_valid, tready);
      end
    end
    // Empty frame directly after the drained oversize frame.
    f = {8'h00, 8'h00};
    send_frame(f, 1'b0, fe, ne);
    exp_frames++;
    n_checks++; if (frame_valid !== 1'b1 || frame_len !== 16'd0) begin
      n_fail++; $display("FAIL empty_frame frame_valid=%b frame_len=%0d req=1/0", frame_valid, frame_len);
    end
    rd_addr = 6'd0; #1;
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL empty_rd0 got=%h req=00", rd_data); end
    n_checks++; if (frame_cnt !== exp_frames || err_cnt !== exp_errs) begin
      n_fail++; $display("FAIL empty_counters got=%0d/%0d req=%0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs);
    end
    @(negedge clk); frame_ack = 1'b1; @(negedge clk); frame_ack = 1'b0;
  endtask

  task automatic test_random_gaps();
    bq_t f;
    int fe, ne, eb, len, n, kind, a;
    logic [7:0] exp_rd;
    for (int k = 0; k < 20; k++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(0, MAX_LEN);
      n    = len;
      if (kind == 7) n = len + $urandom_range(1, 4);
      else if (kind == 8 && len > 0) n = $urandom_range(0, len - 1);
      else if (kind == 9) begin len = $urandom_range(MAX_LEN + 1, MAX_LEN + 6); n = len; end
      f = {};
      f.push_back(8'(len >> 8));
      f.push_back(8'(len));
      repeat (n) f.push_back(8'($urandom));
      eb = model_err_beat(f);
      send_frame(f, 1'b1, fe, ne);
      n_checks++; if (fe !== eb || ne !== ((eb >= 0) ? 1 : 0)) begin
        n_fail++; $display("FAIL rand%0d_err first=%0d count=%0d req_first=%0d", k, fe, ne, eb);
      end
      if (eb >= 0) exp_errs = sat_inc(exp_errs);
      else         exp_frames++;
      n_checks++; if (frame_valid !== (eb < 0)) begin n_fail++; $display("FAIL rand%0d_valid got=%b req=%b", k, frame_valid, eb < 0); end
      n_checks++; if (frame_cnt !== exp_frames || err_cnt !== exp_errs) begin
        n_fail++; $display("FAIL rand%0d_counters got=%0d/%0d req=%0d/%0d", k, frame_cnt, err_cnt, exp_frames, exp_errs);
      end
      if (eb < 0) begin
        n_checks++; if (frame_len !== 16'(len)) begin n_fail++; $display("FAIL rand%0d_len got=%0d req=%0d", k, frame_len, len); end
`ifdef DATA_STREAM_RX_CHECK_EN
        n_checks++; if (match !== model_match(f)) begin n_fail++; $display("FAIL rand%0d_match got=%b req=%b", k, match, model_match(f)); end
`endif
        for (int r = 0; r < 4; r++) begin
          a = $urandom_range(0, (1 << ADDR_W) - 1);
          exp_rd = (a < len) ? f[2+a] : 8'h00;
          rd_addr = ADDR_W'(a); #1;
          n_checks++; if (rd_data !== exp_rd) begin n_fail++; $display("FAIL rand%0d_rd addr=%0d got=%h req=%h", k, a, rd_data, exp_rd); end
        end
        @(negedge clk);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL rand%0d_hold_tready got=%b req=0", k, tready); end
        frame_ack = 1'b1; @(negedge clk); frame_ack = 1'b0;
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rand%0d_ack got=%b req=0", k, frame_valid); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bq_t f;
    int fe, ne;
    f = {8'h00, 8'h08, 8'h10, 8'h20, 8'h30};
    foreach (f[i]) send_byte(f[i], 1'b0, 1'b0);
    reset_n = 1'b0; #1;
    exp_frames = 16'd0; exp_errs = 16'd0;
    n_checks++; if (tready !== 1'b0 || frame_valid !== 1'b0 || frame_len !== 16'd0 || err_pulse !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs tready=%b fv=%b len=%0d ep=%b req=0/0/0/0", tready, frame_valid, frame_len, err_pulse);
    end
    n_checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL midreset_counters got=%0d/%0d req=0/0", frame_cnt, err_cnt);
    end
    @(negedge clk); reset_n = 1'b1; @(negedge clk);
    f = {8'h00, 8'h03, 8'hC1, 8'hC2, 8'hC3};
    send_frame(f, 1'b1, fe, ne);
    exp_frames++;
    n_checks++; if (ne !== 0 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL midreset_next_err pulses=%0d err_cnt=%0d req=0/0", ne, err_cnt); end
    n_checks++; if (frame_valid !== 1'b1 || frame_len !== 16'd3 || frame_cnt !== exp_frames) begin
      n_fail++; $display("FAIL midreset_next_frame fv=%b len=%0d cnt=%0d req=1/3/%0d", frame_valid, frame_len, frame_cnt, exp_frames);
    end
    rd_addr = 6'd2; #1;
    n_checks++; if (rd_data !== 8'hC3) begin n_fail++; $display("FAIL midreset_rd2 got=%h req=c3", rd_data); end
    @(negedge clk); frame_ack = 1'b1; @(negedge clk); frame_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hello();
    test_errors();
    test_random_gaps();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end
endmodule
